cic_comp: RTL

CIC_COMP -- requirements
Module: cic_comp

---
 rtl/cic_comp_pkg.sv | 36 +++
 rtl/cic_comp_mac.sv | 61 ++++++
 rtl/cic_comp.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/cic_comp_pkg.sv
// Shared constants, coefficient sets, FSM state type and R decode for the CIC droop compensator.
package cic_comp_pkg;

  localparam int unsigned TAPS  = 9;
  localparam int unsigned UNIQ  = 5;
  localparam int unsigned NSETS = 4;

  // Mode code: 0..3 select a coefficient set (log2(R) - 1), MODE_BYP passes samples through.
  localparam logic [2:0] MODE_BYP = 3'd4;

  // Q1.14 half-filters c[0..4]; 2*(c0+c1+c2+c3) + c4 == 16384 for every set.
  localparam int COEFF_TABLE [NSETS][UNIQ] = '{
    '{-64, 192, -640, -1024, 19456},
    '{-48, 160, -576,  -896, 19104},
    '{-40, 144, -544,  -832, 18928},
    '{-32, 128, -512,  -768, 18752}
  };

  typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

  function automatic logic [2:0] r_to_mode(input logic [4:0] r);
    case (r)
      5'd2:    return 3'd0;
      5'd4:    return 3'd1;
      5'd8:    return 3'd2;
      5'd16:   return 3'd3;
      default: return MODE_BYP;
    endcase
  endfunction

  // Reduce 0..17 into a delay-line index 0..8.
  function automatic logic [3:0] wrap9(input logic [4:0] v);
    return 4'((v >= 5'd9) ? v - 5'd9 : v);
  endfunction

endpackage

// File: rtl/cic_comp_mac.sv
// Pre-add / multiply / accumulate datapath with round-half-up and saturation to the sample width.
module cic_comp_mac #(
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int ACC_WIDTH   = 36
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_load,
  input  logic                          i_acc_en,
  input  logic signed [DATA_WIDTH-1:0]  i_a,
  input  logic signed [DATA_WIDTH-1:0]  i_b,
  input  logic signed [COEFF_WIDTH-1:0] i_coef,
  output logic signed [DATA_WIDTH-1:0]  o_y,
  output logic                          o_sat
);

  localparam int PROD_W = COEFF_WIDTH + DATA_WIDTH + 1;
  localparam int FRAC   = COEFF_WIDTH - 2;
  localparam logic signed [ACC_WIDTH-1:0] RND     = ACC_WIDTH'(64'sd1 <<< (FRAC - 1));
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
      ACC_WIDTH'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-(64'sd1 <<< (DATA_WIDTH - 1)));

  logic signed [DATA_WIDTH:0]  w_pre;
  logic signed [PROD_W-1:0]    w_prod;
  logic signed [ACC_WIDTH-1:0] w_term;
  logic signed [ACC_WIDTH-1:0] w_rnd;
  logic signed [ACC_WIDTH-1:0] w_shr;
  logic signed [ACC_WIDTH-1:0] r_acc;

  assign w_pre  = {i_a[DATA_WIDTH-1], i_a} + {i_b[DATA_WIDTH-1], i_b};
  assign w_prod = PROD_W'(i_coef) * PROD_W'(w_pre);
  assign w_term = ACC_WIDTH'(w_prod);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc <= '0;
    end else if (i_load) begin
      r_acc <= w_term;
    end else if (i_acc_en) begin
      r_acc <= r_acc + w_term;
    end
  end

  assign w_rnd = r_acc + RND;
  assign w_shr = w_rnd >>> FRAC;

  always_comb begin
    o_sat = 1'b0;
    o_y   = w_shr[DATA_WIDTH-1:0];
    if (w_shr > SAT_MAX) begin
      o_y   = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
      o_sat = 1'b1;
    end else if (w_shr < SAT_MIN) begin
      o_y   = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
      o_sat = 1'b1;
    end
  end

endmodule

// File: rtl/cic_comp.sv
// 9-tap symmetric CIC droop compensator: delay line, sequencing FSM and bypass around the MAC.
module cic_comp
  import cic_comp_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int ACC_WIDTH   = 36
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [4:0]                   R,
  input  logic                         valid_in,
  input  logic signed [DATA_WIDTH-1:0] x_in,
  output logic signed [DATA_WIDTH-1:0] x_out,
  output logic                         valid_out,
  output logic                         sat,
  output logic                         overrun
);

  state_e                       r_state, w_state_nxt;
  logic [2:0]                   r_k;
  logic [3:0]                   r_wr_ptr;
  logic [3:0]                   r_cur;
  logic [2:0]                   r_mode;
  logic signed [DATA_WIDTH-1:0] r_dl [TAPS];
  logic signed [DATA_WIDTH-1:0] r_x_out;
  logic                         r_valid_out;
  logic                         r_sat;
  logic                         r_overrun;

  logic [2:0]                    w_mode;
  logic                          w_accept;
  logic                          w_filt;
  logic                          w_mode_chg;
  logic [1:0]                    w_set;
  logic [2:0]                    w_tap;
  logic signed [DATA_WIDTH-1:0]  w_a;
  logic signed [DATA_WIDTH-1:0]  w_b;
  logic signed [COEFF_WIDTH-1:0] w_coef;
  logic signed [DATA_WIDTH-1:0]  w_y;
  logic                          w_sat;

  assign w_mode     = r_to_mode(R);
  assign w_accept   = valid_in && (r_state == StIdle);
  assign w_filt     = w_accept && (w_mode != MODE_BYP);
  assign w_mode_chg = (w_mode != r_mode);

  // Tap 0 is folded into the accept edge (x[n] taken straight from x_in) so the FSM is back in
  // idle exactly 6 clocks after accepting a sample.
  always_comb begin
    w_a   = '0;
    w_b   = '0;
    w_set = r_mode[1:0];
    w_tap = 3'd0;
    if (r_state == StIdle) begin
      w_a   = x_in;
      w_b   = w_mode_chg ? '0 : r_dl[wrap9({1'b0, r_wr_ptr} + 5'd1)];
      w_set = w_mode[1:0];
    end else if (r_state == StMac) begin
      w_a   = r_dl[wrap9({1'b0, r_cur} + 5'd9 - {2'b00, r_k})];
      w_b   = (r_k == 3'd4) ? '0 : r_dl[wrap9({1'b0, r_cur} + 5'd1 + {2'b00, r_k})];
      w_tap = r_k;
    end
  end

  assign w_coef = COEFF_WIDTH'(COEFF_TABLE[w_set][w_tap]);

  cic_comp_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .COEFF_WIDTH(COEFF_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_load  (w_filt),
    .i_acc_en(r_state == StMac),
    .i_a     (w_a),
    .i_b     (w_b),
    .i_coef  (w_coef),
    .o_y     (w_y),
    .o_sat   (w_sat)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_filt) w_state_nxt = StMac;
      StMac:   if (r_k == 3'd4) w_state_nxt = StOut;
      StOut:   w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_k         <= '0;
      r_wr_ptr    <= '0;
      r_cur       <= '0;
      r_mode      <= MODE_BYP;
      r_x_out     <= '0;
      r_valid_out <= 1'b0;
      r_sat       <= 1'b0;
      r_overrun   <= 1'b0;
      for (int i = 0; i < TAPS; i++) r_dl[i] <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_valid_out <= 1'b0;
      if (valid_in && (r_state != StIdle)) r_overrun <= 1'b1;
      if (w_accept) begin
        r_mode <= w_mode;
        // Stale history from another mode must not leak into the new filter.
        if (w_mode_chg) begin
          for (int i = 0; i < TAPS; i++) r_dl[i] <= '0;
        end
        if (w_mode == MODE_BYP) begin
          r_x_out     <= x_in;
          r_valid_out <= 1'b1;
          r_sat       <= 1'b0;
        end else begin
          r_dl[r_wr_ptr] <= x_in;
          r_cur          <= r_wr_ptr;
          r_wr_ptr       <= wrap9({1'b0, r_wr_ptr} + 5'd1);
          r_k            <= 3'd1;
        end
      end
      if (r_state == StMac) r_k <= r_k + 3'd1;
      if (r_state == StOut) begin
        r_x_out     <= w_y;
        r_sat       <= w_sat;
        r_valid_out <= 1'b1;
      end
    end
  end

  assign x_out     = r_x_out;
  assign valid_out = r_valid_out;
  assign sat       = r_sat;
  assign overrun   = r_overrun;

endmodule
